l2_req_arbiter: RTL and testbench

Sequencing arbiter that shares the single L1-facing request port of the unified L2 cache between the instruction cache and the data cache. It grants one L1 transaction at a time and registers the winner's request fields. It presents them to the L2 with a req/addrOK handshake, then routes the L2 dataOK and line data back to the owner only. Data cache has priority. An optional starvation guard bounds instruction-fetch latency under sustained data traffic.

---
 rtl/l2arb_pkg.sv | 35 +++
 rtl/l2_arb_starve_ctr.sv | 39 +++
 rtl/l2_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_l2_req_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2arb_pkg.sv
// Shared types for the L2 request arbiter: FSM states, owner and request-source
// codes, and the bundle of request fields registered at grant time.
package l2arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    FROM_NONE = 2'd0,
    FROM_I    = 2'd1,
    FROM_DR   = 2'd2,
    FROM_DW   = 2'd3
  } from_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
    logic        wr;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic        suc;
    from_e       from;
  } l2_fields_t;

  localparam logic [1:0] ICACHE_SIZE = 2'd2;

endpackage

// File: rtl/l2_arb_starve_ctr.sv
// Saturating count of dcache grants taken while icache waits; raises override
// once the count reaches STARVE_LIMIT so the next contested grant goes to icache.
module l2_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_idle,
  input  logic icache_req,
  input  logic grant_i,
  input  logic grant_d,
  output logic override
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i || (in_idle && !icache_req)) begin
      cnt_d = '0;
    end else if (grant_d && icache_req && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign override = (cnt_q == LIMIT);

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the L2's single L1-facing request port between icache and dcache.
// Define L2ARB_STARVE_GUARD_EN to bound icache starvation under dcache traffic.
module l2_req_arbiter
  import l2arb_pkg::*;
#(
  parameter int L1_OFFSET_WIDTH = 2,
  parameter int STARVE_LIMIT    = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  icache_arb_req,
  input  logic [31:0]                           addr_icache_arb,
  input  logic                                  icache_arb_SUC,
  output logic                                  arb_icache_addrOK,
  output logic                                  arb_icache_dataOK,
  output logic [32*(1<<L1_OFFSET_WIDTH)-1:0]    dout_arb_icache,
  input  logic                                  dcache_arb_req,
  input  logic                                  dcache_arb_wr,
  input  logic [31:0]                           addr_dcache_arb,
  input  logic [31:0]                           din_dcache_arb,
  input  logic [3:0]                            dcache_arb_wstrb,
  input  logic [1:0]                            dcache_arb_size,
  input  logic                                  dcache_arb_SUC,
  output logic                                  arb_dcache_addrOK,
  output logic                                  arb_dcache_dataOK,
  output logic [32*(1<<L1_OFFSET_WIDTH)-1:0]    dout_arb_dcache,
  output logic                                  arb_l2_req,
  output logic                                  arb_l2_wr,
  output logic                                  arb_l2_SUC,
  output logic [31:0]                           addr_arb_l2,
  output logic [31:0]                           din_arb_l2,
  output logic [3:0]                            arb_l2_wstrb,
  output logic [1:0]                            arb_l2_size,
  output logic [1:0]                            arb_l2_from,
  input  logic                                  l2_arb_addrOK,
  input  logic                                  l2_arb_dataOK,
  input  logic [32*(1<<L1_OFFSET_WIDTH)-1:0]    dout_l2_arb,
  output logic                                  arb_busy
);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  l2_fields_t fields_q, fields_d;

  logic in_idle;
  logic grant_i;
  logic grant_d;
  logic done;
  logic starve_override;

`ifdef L2ARB_STARVE_GUARD_EN
  l2_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_starve_ctr (
    .clk        (clk),
    .rstn       (rstn),
    .in_idle    (in_idle),
    .icache_req (icache_arb_req),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .override   (starve_override)
  );
`else
  logic unused_cfg;
  assign unused_cfg      = (STARVE_LIMIT == CNT_WIDTH);
  assign starve_override = 1'b0;
`endif

  // Grants and completions are qualified by rstn so a reset cycle never
  // emits a handshake, even though the state register only clears at the edge.
  always_comb begin
    in_idle = (state_q == IDLE);
    grant_d = rstn && in_idle && dcache_arb_req &&
              !(starve_override && icache_arb_req);
    grant_i = rstn && in_idle && icache_arb_req && !grant_d;
    done    = rstn && (((state_q == REQ) && l2_arb_addrOK && l2_arb_dataOK) ||
                       ((state_q == WAIT) && l2_arb_dataOK));
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    fields_d = fields_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d        = OWN_D;
          fields_d.addr  = addr_dcache_arb;
          fields_d.din   = din_dcache_arb;
          fields_d.wr    = dcache_arb_wr;
          fields_d.wstrb = dcache_arb_wstrb;
          fields_d.size  = dcache_arb_size;
          fields_d.suc   = dcache_arb_SUC;
          fields_d.from  = dcache_arb_wr ? FROM_DW : FROM_DR;
          state_d        = REQ;
        end else if (grant_i) begin
          owner_d        = OWN_I;
          fields_d.addr  = addr_icache_arb;
          fields_d.din   = '0;
          fields_d.wr    = 1'b0;
          fields_d.wstrb = '0;
          fields_d.size  = ICACHE_SIZE;
          fields_d.suc   = icache_arb_SUC;
          fields_d.from  = FROM_I;
          state_d        = REQ;
        end
      end
      REQ: begin
        if (l2_arb_addrOK) begin
          state_d = l2_arb_dataOK ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (l2_arb_dataOK) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      fields_q <= fields_d;
    end
  end

  always_comb begin
    arb_icache_addrOK = grant_i;
    arb_dcache_addrOK = grant_d;
    arb_icache_dataOK = done && (owner_q == OWN_I);
    arb_dcache_dataOK = done && (owner_q == OWN_D);
    dout_arb_icache   = arb_icache_dataOK ? dout_l2_arb : '0;
    dout_arb_dcache   = arb_dcache_dataOK ? dout_l2_arb : '0;
    arb_l2_req        = rstn && (state_q == REQ);
    arb_l2_wr         = fields_q.wr;
    arb_l2_SUC        = fields_q.suc;
    addr_arb_l2       = fields_q.addr;
    din_arb_l2        = fields_q.din;
    arb_l2_wstrb      = fields_q.wstrb;
    arb_l2_size       = fields_q.size;
    arb_l2_from       = fields_q.from;
    arb_busy          = (state_q != IDLE);
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_l2_req_arbiter;

  localparam int LINE_W       = 128;
  localparam int STARVE_LIMIT = 4;
`ifdef L2ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic              icache_arb_req;
  logic [31:0]       addr_icache_arb;
  logic              icache_arb_SUC;
  logic              arb_icache_addrOK;
  logic              arb_icache_dataOK;
  logic [LINE_W-1:0] dout_arb_icache;
  logic              dcache_arb_req;
  logic              dcache_arb_wr;
  logic [31:0]       addr_dcache_arb;
  logic [31:0]       din_dcache_arb;
  logic [3:0]        dcache_arb_wstrb;
  logic [1:0]        dcache_arb_size;
  logic              dcache_arb_SUC;
  logic              arb_dcache_addrOK;
  logic              arb_dcache_dataOK;
  logic [LINE_W-1:0] dout_arb_dcache;
  logic              arb_l2_req;
  logic              arb_l2_wr;
  logic              arb_l2_SUC;
  logic [31:0]       addr_arb_l2;
  logic [31:0]       din_arb_l2;
  logic [3:0]        arb_l2_wstrb;
  logic [1:0]        arb_l2_size;
  logic [1:0]        arb_l2_from;
  logic              l2_arb_addrOK;
  logic              l2_arb_dataOK;
  logic [LINE_W-1:0] dout_l2_arb;
  logic              arb_busy;

  int checks   = 0;
  int failures = 0;

  l2_req_arbiter #(
    .L1_OFFSET_WIDTH (2),
    .STARVE_LIMIT    (STARVE_LIMIT),
    .CNT_WIDTH       (3)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .icache_arb_req    (icache_arb_req),
    .addr_icache_arb   (addr_icache_arb),
    .icache_arb_SUC    (icache_arb_SUC),
    .arb_icache_addrOK (arb_icache_addrOK),
    .arb_icache_dataOK (arb_icache_dataOK),
    .dout_arb_icache   (dout_arb_icache),
    .dcache_arb_req    (dcache_arb_req),
    .dcache_arb_wr     (dcache_arb_wr),
    .addr_dcache_arb   (addr_dcache_arb),
    .din_dcache_arb    (din_dcache_arb),
    .dcache_arb_wstrb  (dcache_arb_wstrb),
    .dcache_arb_size   (dcache_arb_size),
    .dcache_arb_SUC    (dcache_arb_SUC),
    .arb_dcache_addrOK (arb_dcache_addrOK),
    .arb_dcache_dataOK (arb_dcache_dataOK),
    .dout_arb_dcache   (dout_arb_dcache),
    .arb_l2_req        (arb_l2_req),
    .arb_l2_wr         (arb_l2_wr),
    .arb_l2_SUC        (arb_l2_SUC),
    .addr_arb_l2       (addr_arb_l2),
    .din_arb_l2        (din_arb_l2),
    .arb_l2_wstrb      (arb_l2_wstrb),
    .arb_l2_size       (arb_l2_size),
    .arb_l2_from       (arb_l2_from),
    .l2_arb_addrOK     (l2_arb_addrOK),
    .l2_arb_dataOK     (l2_arb_dataOK),
    .dout_l2_arb       (dout_l2_arb),
    .arb_busy          (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    icache_arb_req   = 1'b0;
    addr_icache_arb  = '0;
    icache_arb_SUC   = 1'b0;
    dcache_arb_req   = 1'b0;
    dcache_arb_wr    = 1'b0;
    addr_dcache_arb  = '0;
    din_dcache_arb   = '0;
    dcache_arb_wstrb = '0;
    dcache_arb_size  = '0;
    dcache_arb_SUC   = 1'b0;
    l2_arb_addrOK    = 1'b0;
    l2_arb_dataOK    = 1'b0;
    dout_l2_arb      = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    icache_arb_req = 1'b1;
    dcache_arb_req = 1'b1;
    l2_arb_dataOK  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({arb_icache_addrOK, arb_dcache_addrOK, arb_icache_dataOK, arb_dcache_dataOK,
         arb_l2_req, arb_busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_handshakes: got %b want 000000", {arb_icache_addrOK,
               arb_dcache_addrOK, arb_icache_dataOK, arb_dcache_dataOK, arb_l2_req, arb_busy});
    end
    checks++;
    if ({addr_arb_l2, din_arb_l2, arb_l2_wr, arb_l2_SUC, arb_l2_wstrb, arb_l2_size,
         arb_l2_from} !== 74'b0 || dout_arb_icache !== '0 || dout_arb_dcache !== '0) begin
      failures++;
      $display("FAIL reset_fields: addr=%h din=%h from=%0d dout_i=%h dout_d=%h want all 0",
               addr_arb_l2, din_arb_l2, arb_l2_from, dout_arb_icache, dout_arb_dcache);
    end
    #1 rstn = 1'b1;
    clear_inputs();
  endtask

  task automatic test_icache_read();
    logic [LINE_W-1:0] line;
    line = {(LINE_W/8){8'hA5}};
    apply_reset();
    icache_arb_req  = 1'b1;
    addr_icache_arb = 32'h1000_0040;
    @(negedge clk);
    checks++;
    if ({arb_icache_addrOK, arb_dcache_addrOK, arb_busy} !== 3'b100) begin
      failures++;
      $display("FAIL iread_c0_addrok: got {aok_i,aok_d,busy}=%b want 100",
               {arb_icache_addrOK, arb_dcache_addrOK, arb_busy});
    end
    next_cycle();
    icache_arb_req  = 1'b0;
    addr_icache_arb = '0;
    l2_arb_addrOK   = 1'b1;
    @(negedge clk);
    checks++;
    if ({arb_l2_req, addr_arb_l2, arb_l2_from, arb_l2_wr, arb_l2_wstrb, arb_l2_size} !==
        {1'b1, 32'h1000_0040, 2'd1, 1'b0, 4'b0, 2'd2}) begin
      failures++;
      $display("FAIL iread_c1_req: req=%b addr=%h from=%0d wr=%b wstrb=%h size=%0d want 1 10000040 1 0 0 2",
               arb_l2_req, addr_arb_l2, arb_l2_from, arb_l2_wr, arb_l2_wstrb, arb_l2_size);
    end
    next_cycle();
    l2_arb_addrOK = 1'b0;
    @(negedge clk);
    checks++;
    if ({arb_l2_req, arb_busy, arb_icache_dataOK} !== 3'b010) begin
      failures++;
      $display("FAIL iread_c2_wait: got {req,busy,dok_i}=%b want 010",
               {arb_l2_req, arb_busy, arb_icache_dataOK});
    end
    next_cycle();
    l2_arb_dataOK = 1'b1;
    dout_l2_arb   = line;
    @(negedge clk);
    checks++;
    if (arb_icache_dataOK !== 1'b1 || dout_arb_icache !== line || arb_dcache_dataOK !== 1'b0 ||
        dout_arb_dcache !== '0 || arb_dcache_addrOK !== 1'b0) begin
      failures++;
      $display("FAIL iread_c3_data: dok_i=%b dout_i=%h dok_d=%b dout_d=%h want 1 %h 0 0",
               arb_icache_dataOK, dout_arb_icache, arb_dcache_dataOK, dout_arb_dcache, line);
    end
    next_cycle();
    l2_arb_dataOK = 1'b0;
    dout_l2_arb   = '0;
    @(negedge clk);
    checks++;
    if ({arb_busy, arb_icache_dataOK} !== 2'b00) begin
      failures++;
      $display("FAIL iread_c4_idle: got {busy,dok_i}=%b want 00", {arb_busy, arb_icache_dataOK});
    end
  endtask

  task automatic test_dcache_write();
    logic [73:0] want;
    apply_reset();
    dcache_arb_req   = 1'b1;
    dcache_arb_wr    = 1'b1;
    addr_dcache_arb  = 32'h2000_0004;
    din_dcache_arb   = 32'hDEAD_BEEF;
    dcache_arb_wstrb = 4'b0011;
    dcache_arb_size  = 2'd1;
    dcache_arb_SUC   = 1'b1;
    want = {1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 2'd1, 2'd3};
    @(negedge clk);
    checks++;
    if (arb_dcache_addrOK !== 1'b1) begin
      failures++;
      $display("FAIL dwr_addrok: got %b want 1", arb_dcache_addrOK);
    end
    next_cycle();
    clear_inputs();
    // L2 accepts one cycle late, then the response arrives two cycles later.
    for (int c = 1; c <= 4; c++) begin
      l2_arb_addrOK = (c == 2);
      l2_arb_dataOK = (c == 4);
      dout_l2_arb   = {4{32'h0000_0001 * c}};
      @(negedge clk);
      checks++;
      if ({arb_l2_wr, arb_l2_SUC, addr_arb_l2, din_arb_l2, arb_l2_wstrb, arb_l2_size,
           arb_l2_from} !== want || arb_l2_req !== (c <= 2) || arb_dcache_dataOK !== (c == 4) ||
          arb_icache_dataOK !== 1'b0) begin
        failures++;
        $display("FAIL dwr_hold_c%0d: addr=%h din=%h wstrb=%h from=%0d req=%b dok_d=%b dok_i=%b",
                 c, addr_arb_l2, din_arb_l2, arb_l2_wstrb, arb_l2_from, arb_l2_req,
                 arb_dcache_dataOK, arb_icache_dataOK);
      end
      next_cycle();
    end
    // dataOK left high in IDLE must not produce a second completion.
    l2_arb_addrOK = 1'b0;
    l2_arb_dataOK = 1'b1;
    @(negedge clk);
    checks++;
    if ({arb_dcache_dataOK, arb_busy, dout_arb_dcache != '0} !== 3'b000) begin
      failures++;
      $display("FAIL dwr_single_dataok: got {dok_d,busy,dout_nz}=%b want 000",
               {arb_dcache_dataOK, arb_busy, dout_arb_dcache != '0});
    end
  endtask

  task automatic test_both_simultaneous();
    logic [LINE_W-1:0] line;
    apply_reset();
    icache_arb_req  = 1'b1;
    addr_icache_arb = 32'h0000_1230;
    dcache_arb_req  = 1'b1;
    addr_dcache_arb = 32'h0000_4560;
    dcache_arb_size = 2'd2;
    @(negedge clk);
    checks++;
    if ({arb_dcache_addrOK, arb_icache_addrOK} !== 2'b10) begin
      failures++;
      $display("FAIL both_first: got {aok_d,aok_i}=%b want 10", {arb_dcache_addrOK, arb_icache_addrOK});
    end
    next_cycle();
    dcache_arb_req = 1'b0;
    line = {$urandom, $urandom, $urandom, $urandom};
    l2_arb_addrOK = 1'b1;
    l2_arb_dataOK = 1'b1;
    dout_l2_arb   = line;
    @(negedge clk);
    checks++;
    if (arb_l2_req !== 1'b1 || arb_l2_from !== 2'd2 || arb_dcache_dataOK !== 1'b1 ||
        dout_arb_dcache !== line || arb_icache_dataOK !== 1'b0 || dout_arb_icache !== '0) begin
      failures++;
      $display("FAIL both_fast_done: req=%b from=%0d dok_d=%b dout_d=%h dok_i=%b want 1 2 1 %h 0",
               arb_l2_req, arb_l2_from, arb_dcache_dataOK, dout_arb_dcache, arb_icache_dataOK, line);
    end
    next_cycle();
    l2_arb_addrOK = 1'b0;
    l2_arb_dataOK = 1'b0;
    @(negedge clk);
    checks++;
    if ({arb_busy, arb_icache_addrOK, arb_l2_req, arb_dcache_dataOK} !== 4'b0100) begin
      failures++;
      $display("FAIL both_second: got {busy,aok_i,req,dok_d}=%b want 0100",
               {arb_busy, arb_icache_addrOK, arb_l2_req, arb_dcache_dataOK});
    end
    next_cycle();
    icache_arb_req = 1'b0;
    l2_arb_addrOK  = 1'b1;
    l2_arb_dataOK  = 1'b1;
    @(negedge clk);
    checks++;
    if ({arb_l2_from, addr_arb_l2, arb_icache_dataOK} !== {2'd1, 32'h0000_1230, 1'b1}) begin
      failures++;
      $display("FAIL both_icache_done: from=%0d addr=%h dok_i=%b want 1 00001230 1",
               arb_l2_from, addr_arb_l2, arb_icache_dataOK);
    end
  endtask

  task automatic test_starvation();
    int grants;
    int first_i;
    int want_first;
    apply_reset();
    dcache_arb_req = 1'b1;
    icache_arb_req = 1'b1;
    l2_arb_addrOK  = 1'b1;
    l2_arb_dataOK  = 1'b1;
    grants  = 0;
    first_i = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (arb_dcache_addrOK || arb_icache_addrOK) grants++;
      if (arb_icache_addrOK && first_i == 0) first_i = grants;
      next_cycle();
    end
    clear_inputs();
    want_first = GUARD ? STARVE_LIMIT + 1 : 0;
    checks++;
    if (first_i !== want_first) begin
      failures++;
      $display("FAIL starve_first_icache_grant: got %0d want %0d", first_i, want_first);
    end
    checks++;
    if (grants !== 20) begin
      failures++;
      $display("FAIL starve_grant_count: got %0d want 20", grants);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    dcache_arb_req  = 1'b1;
    dcache_arb_wr   = 1'b1;
    addr_dcache_arb = 32'h3000_0008;
    din_dcache_arb  = 32'h1234_5678;
    next_cycle();
    clear_inputs();
    l2_arb_addrOK = 1'b1;
    next_cycle();
    l2_arb_addrOK = 1'b0;
    @(negedge clk);
    checks++;
    if ({arb_busy, arb_l2_req} !== 2'b10) begin
      failures++;
      $display("FAIL rstwait_in_wait: got {busy,req}=%b want 10", {arb_busy, arb_l2_req});
    end
    next_cycle();
    rstn          = 1'b0;
    l2_arb_dataOK = 1'b1;
    dout_l2_arb   = {4{32'hCAFE_F00D}};
    @(negedge clk);
    checks++;
    if ({arb_dcache_dataOK, arb_icache_dataOK} !== 2'b00 || dout_arb_dcache !== '0) begin
      failures++;
      $display("FAIL rstwait_no_dataok: got {dok_d,dok_i}=%b dout_d=%h want 00 0",
               {arb_dcache_dataOK, arb_icache_dataOK}, dout_arb_dcache);
    end
    next_cycle();
    rstn = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({arb_busy, arb_l2_req, arb_dcache_dataOK, addr_arb_l2, din_arb_l2, arb_l2_wr,
         arb_l2_from} !== 70'b0) begin
      failures++;
      $display("FAIL rstwait_idle: busy=%b req=%b dok_d=%b addr=%h din=%h wr=%b from=%0d want all 0",
               arb_busy, arb_l2_req, arb_dcache_dataOK, addr_arb_l2, din_arb_l2, arb_l2_wr, arb_l2_from);
    end
  endtask

  // Randomized traffic: L1s hold requests until accepted, L2 responds with random
  // delays and occasional stray dataOK. Expectations come from a model kept as a
  // busy flag, an "address accepted" flag, the owning side and the captured fields.
  task automatic test_random();
    bit          i_pend, d_pend;
    bit          m_busy, m_acc, m_own_d;
    int          m_starve;
    logic [73:0] m_fields;
    bit          d_wins, g_i, g_d, done_e;
    logic [73:0] obs_fields;
    int          n_i, n_d;
    apply_reset();
    i_pend = 0; d_pend = 0;
    m_busy = 0; m_acc = 0; m_own_d = 0; m_starve = 0; m_fields = '0;
    n_i = 0; n_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend          = 1;
        addr_icache_arb = $urandom;
        icache_arb_SUC  = 1'($urandom);
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend           = 1;
        dcache_arb_wr    = 1'($urandom);
        addr_dcache_arb  = $urandom;
        din_dcache_arb   = $urandom;
        dcache_arb_wstrb = 4'($urandom);
        dcache_arb_size  = 2'($urandom);
        dcache_arb_SUC   = 1'($urandom);
      end
      icache_arb_req = i_pend;
      dcache_arb_req = d_pend;
      l2_arb_addrOK  = (m_busy && !m_acc) ? 1'($urandom) : 1'b0;
      l2_arb_dataOK  = ($urandom_range(0, 2) == 0);
      dout_l2_arb    = {$urandom, $urandom, $urandom, $urandom};

      @(negedge clk);
      d_wins = dcache_arb_req && !(GUARD && m_starve == STARVE_LIMIT && icache_arb_req);
      g_d    = !m_busy && d_wins;
      g_i    = !m_busy && icache_arb_req && !d_wins;
      done_e = m_busy && l2_arb_dataOK && (m_acc || l2_arb_addrOK);
      obs_fields = {arb_l2_wr, arb_l2_SUC, addr_arb_l2, din_arb_l2, arb_l2_wstrb,
                    arb_l2_size, arb_l2_from};

      checks++;
      if ({arb_icache_addrOK, arb_dcache_addrOK} !== {g_i, g_d}) begin
        failures++;
        $display("FAIL rnd_addrok cyc=%0d: got {i,d}=%b want %b", cyc,
                 {arb_icache_addrOK, arb_dcache_addrOK}, {g_i, g_d});
      end
      checks++;
      if ({arb_busy, arb_l2_req} !== {m_busy, m_busy && !m_acc}) begin
        failures++;
        $display("FAIL rnd_busy_req cyc=%0d: got {busy,req}=%b want %b", cyc,
                 {arb_busy, arb_l2_req}, {m_busy, m_busy && !m_acc});
      end
      checks++;
      if (obs_fields !== m_fields) begin
        failures++;
        $display("FAIL rnd_fields cyc=%0d: got %h want %h", cyc, obs_fields, m_fields);
      end
      checks++;
      if ({arb_icache_dataOK, arb_dcache_dataOK} !== {done_e && !m_own_d, done_e && m_own_d} ||
          dout_arb_icache !== ((done_e && !m_own_d) ? dout_l2_arb : '0) ||
          dout_arb_dcache !== ((done_e && m_own_d) ? dout_l2_arb : '0)) begin
        failures++;
        $display("FAIL rnd_dataok cyc=%0d: got {i,d}=%b want %b dout_i=%h dout_d=%h", cyc,
                 {arb_icache_dataOK, arb_dcache_dataOK}, {done_e && !m_own_d, done_e && m_own_d},
                 dout_arb_icache, dout_arb_dcache);
      end

      if (!m_busy) begin
        if (g_i || !icache_arb_req) m_starve = 0;
        else if (g_d && m_starve < STARVE_LIMIT) m_starve++;
      end
      if (g_d) begin
        m_busy = 1; m_acc = 0; m_own_d = 1; d_pend = 0; n_d++;
        m_fields = {dcache_arb_wr, dcache_arb_SUC, addr_dcache_arb, din_dcache_arb,
                    dcache_arb_wstrb, dcache_arb_size, dcache_arb_wr ? 2'd3 : 2'd2};
      end else if (g_i) begin
        m_busy = 1; m_acc = 0; m_own_d = 0; i_pend = 0; n_i++;
        m_fields = {1'b0, icache_arb_SUC, addr_icache_arb, 32'h0, 4'h0, 2'd2, 2'd1};
      end else if (done_e) begin
        m_busy = 0;
      end else if (m_busy && l2_arb_addrOK) begin
        m_acc = 1;
      end
      next_cycle();
    end
    clear_inputs();
    checks++;
    if (n_d == 0 || (GUARD && n_i == 0)) begin
      failures++;
      $display("FAIL rnd_coverage: dcache grants=%0d icache grants=%0d", n_d, n_i);
    end
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_both_simultaneous();
    test_starvation();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
